cond_flag_unit: RTL

- Consumer end of the ALU flag interface. Holds the architectural NZCV register and updates it from the ALU's negative/zero/overflow/carry_out outputs on flag-setting ops.
- Resolves B.cond requests against NZCV using a valid/ready handshake.
- Stalls a request while flag-setting ops are still in flight.
- Sits between the ALU and the PC/branch logic of the single-cycle/pipelined CPU.

---
 rtl/cond_pkg.sv | 41 ++++
 rtl/cond_eval.sv | 45 ++++
 rtl/cond_flag_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types and constants for the condition/flag unit and the decode-stage
// condition evaluator.
package cond_pkg;

  // ARM condition codes as carried on br_cond
  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  // Branch resolution FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } state_e;

  localparam int unsigned NZCV_W = 4;
  localparam int unsigned N_BIT  = 3;
  localparam int unsigned Z_BIT  = 2;
  localparam int unsigned C_BIT  = 1;
  localparam int unsigned V_BIT  = 0;

  localparam int unsigned PEND_W   = 2;
  localparam logic [1:0]  PEND_MAX = 2'd3;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of an ARM condition code against an NZCV value.
// Shared with the decode stage.
module cond_eval
  import cond_pkg::*;
(
  input  cond_e                 cond,
  input  logic [NZCV_W-1:0]     nzcv,
  output logic                  taken
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[N_BIT];
  assign z = nzcv[Z_BIT];
  assign c = nzcv[C_BIT];
  assign v = nzcv[V_BIT];

  // Condition truth table; AL and NV are both always-taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      EQ: taken = z;
      NE: taken = !z;
      CS: taken = c;
      CC: taken = !c;
      MI: taken = n;
      PL: taken = !n;
      VS: taken = v;
      VC: taken = !v;
      HI: taken = c && !z;
      LS: taken = !c || z;
      GE: taken = (n == v);
      LT: taken = (n != v);
      GT: taken = !z && (n == v);
      LE: taken = z || (n != v);
      AL: taken = 1'b1;
      NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register plus B.cond resolver. Requests stall while
// flag-setting ops are still outstanding.
// Optional macro COND_FLAG_FWD_EN: release a stalled request in the same cycle
// that retires the last outstanding flag op (saves one WAIT cycle).
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flag_issue,
  input  logic               alu_valid,
  input  logic               alu_setflags,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_carry_out,
  input  logic               br_valid,
  input  logic [3:0]         br_cond,
  output logic               br_ready,
  output logic               res_valid,
  output logic               res_taken,
  output logic [3:0]         nzcv,
  output logic               pend_full,
  output logic [CNT_W-1:0]   taken_cnt
);

  state_e              state;
  state_e              state_next;
  cond_e               cond_q;
  cond_e               cond_next;

  logic [NZCV_W-1:0]   nzcv_next;
  logic [PEND_W-1:0]   pend;
  logic [PEND_W-1:0]   pend_next;
  logic [PEND_W-1:0]   pend_chk;
  logic                retire;
  logic                issue_acc;
  logic                pend_dec;

  logic                eval_taken_c;
  logic                br_ready_next;
  logic                res_valid_next;
  logic                res_taken_next;
  logic                pend_full_next;
  logic [CNT_W-1:0]    taken_cnt_next;

  // Flag write and outstanding flag-op bookkeeping
  always_comb begin
    retire    = alu_valid && alu_setflags;
    nzcv_next = nzcv;
    if (retire) begin
      nzcv_next = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    end
    // A full counter only takes a new issue if a retire frees a slot
    issue_acc = flag_issue && ((pend != PEND_MAX) || retire);
    // Retire with nothing outstanding still writes flags but never underflows
    pend_dec  = retire && (pend != PEND_W'(0));
    pend_next = pend;
    if (issue_acc && !pend_dec) begin
      pend_next = pend + PEND_W'(1);
    end else if (!issue_acc && pend_dec) begin
      pend_next = pend - PEND_W'(1);
    end
  end

  // Hazard check source: forwarded next count or registered count
`ifdef COND_FLAG_FWD_EN
  assign pend_chk = pend_next;
`else
  assign pend_chk = pend;
`endif

  // Next-state logic
  always_comb begin
    state_next = state;
    cond_next  = cond_q;
    case (state)
      IDLE: begin
        if (br_valid) begin
          cond_next = cond_e'(br_cond);
          if (pend_chk == PEND_W'(0)) begin
            state_next = EVAL;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (pend_chk == PEND_W'(0)) begin
          state_next = EVAL;
        end
      end
      EVAL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Evaluate against the NZCV value that will be registered when EVAL starts
  cond_eval u_cond_eval (
    .cond  (cond_next),
    .nzcv  (nzcv_next),
    .taken (eval_taken_c)
  );

  // Moore output decode, registered alongside the state
  always_comb begin
    br_ready_next  = (state_next == IDLE);
    res_valid_next = (state_next == EVAL);
    res_taken_next = (state_next == EVAL) && eval_taken_c;
    pend_full_next = (pend_next == PEND_MAX);
    taken_cnt_next = taken_cnt;
    if ((state == EVAL) && res_taken) begin
      taken_cnt_next = taken_cnt + CNT_W'(1);
    end
  end

  // State register and latched condition code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cond_q <= EQ;
    end else begin
      state  <= state_next;
      cond_q <= cond_next;
    end
  end

  // Architectural flags and outstanding-op counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv      <= 4'b0000;
      pend      <= PEND_W'(0);
      pend_full <= 1'b0;
    end else begin
      nzcv      <= nzcv_next;
      pend      <= pend_next;
      pend_full <= pend_full_next;
    end
  end

  // Handshake, result and statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      taken_cnt <= CNT_W'(0);
    end else begin
      br_ready  <= br_ready_next;
      res_valid <= res_valid_next;
      res_taken <= res_taken_next;
      taken_cnt <= taken_cnt_next;
    end
  end

endmodule
